// File: rtl/ipq_pkg.sv
// Shared types for the instruction prefetch queue: FSM state, queue entry layout
// and the fetch word size.
package ipq_pkg;

  typedef enum logic {FETCH, DRAIN} ipq_state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ipq_entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// Circular buffer of prefetched {pc, data} entries with synchronous clear.
// Push while full is accepted only together with a pop.
module ipq_fifo
  import ipq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  ipq_entry_t                 i_push_data,
  input  logic                       i_pop,
  output ipq_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ipq_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch queue: credit-limited sequential fetch, in-order response
// buffering, flush/redirect with drain of in-flight words. Option: IPQ_BYPASS_EN.
module instr_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  ipq_state_t    r_state;
  ipq_state_t    w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_count;
  logic          w_empty;
  ipq_entry_t    w_head;
  ipq_entry_t    w_push_entry;
  logic          w_credit_ok;
  logic          w_req_fire;
  logic          w_rsp_accept;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // Words in the queue plus words in flight never exceed DEPTH, so every response has a slot.
  assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);

  assign o_imem_req_valid   = !i_reset && (r_state == FETCH) && !i_flush && w_credit_ok;
  assign o_imem_req_addr    = r_fetch_pc;
  assign w_req_fire         = o_imem_req_valid && i_imem_req_ready;
  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
  assign w_rsp_accept       = (r_state == FETCH) && !i_flush && i_imem_rsp_valid;

`ifdef IPQ_BYPASS_EN
  assign w_bypass = w_empty && (r_state == FETCH) && !i_flush && i_imem_rsp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = w_rsp_accept && !(w_bypass && !i_stall);
  assign w_pop        = !w_empty && !i_stall && !i_flush;
  assign w_push_entry = '{pc: r_rsp_pc, data: i_imem_rsp_data};

  ipq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_flush),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  always_comb begin
    o_instr_valid = 1'b0;
    o_instr       = 32'h0;
    o_instr_pc    = 32'h0;
    if (!i_reset) begin
      if (w_bypass) begin
        o_instr_valid = 1'b1;
        o_instr       = i_imem_rsp_data;
        o_instr_pc    = r_rsp_pc;
      end else if (!w_empty) begin
        o_instr_valid = 1'b1;
        o_instr       = w_head.data;
        o_instr_pc    = w_head.pc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: if (i_flush && (w_outstanding_next != '0)) w_state_next = DRAIN;
      DRAIN: if (w_outstanding_next == '0) w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= FETCH;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      if (i_flush) begin
        r_fetch_pc <= i_redirect_pc;
        r_rsp_pc   <= i_redirect_pc;
      end else begin
        if (w_req_fire)   r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
        if (w_rsp_accept) r_rsp_pc   <= r_rsp_pc + 32'(WORD_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order fixed-latency memory model.
// Honours IPQ_BYPASS_EN for the first-instruction latency check.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, req_ready, stall, flush;
  logic [31:0] redirect_pc;
  logic        req_valid, rsp_valid, instr_valid;
  logic [31:0] req_addr, rsp_data, instr, instr_pc;

  int          lat;
  logic [3:0]  stg_v;
  logic [31:0] stg_a [4];
  logic [31:0] acc_addr [$];
  logic [31:0] cons_pc [$];
  logic [31:0] cons_data [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign rsp_valid = stg_v[lat-1];
  assign rsp_data  = memWord(stg_a[lat-1]);

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_imem_req_valid (req_valid),
    .o_imem_req_addr  (req_addr),
    .i_imem_req_ready (req_ready),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc)
  );

  // Memory pipeline plus request and consumption logs.
  always @(posedge clk) begin
    if (reset) begin
      stg_v <= '0;
      for (int i = 0; i < 4; i++) stg_a[i] <= 32'h0;
      acc_addr.delete();
      cons_pc.delete();
      cons_data.delete();
    end else begin
      stg_v    <= {stg_v[2:0], req_valid && req_ready};
      stg_a[0] <= req_addr;
      for (int i = 1; i < 4; i++) stg_a[i] <= stg_a[i-1];
      if (req_valid && req_ready) acc_addr.push_back(req_addr);
      if (instr_valid && !stall && !flush) begin
        cons_pc.push_back(instr_pc);
        cons_data.push_back(instr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset(input int latency, input logic stallVal);
    reset = 1'b1; lat = latency; stall = stallVal; flush = 1'b0;
    req_ready = 1'b1; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkPc(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (cons_pc.size() <= idx) begin
      errors++;
      $display("[TB] FAIL %s: got %0d consumed expected more than %0d", name, cons_pc.size(), idx);
    end else if (cons_pc[idx] !== exp || cons_data[idx] !== memWord(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got pc %h data %h expected pc %h data %h",
               name, cons_pc[idx], cons_data[idx], exp, memWord(exp));
    end
  endtask

  task automatic chkAcc(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (acc_addr.size() <= idx) begin
      errors++;
      $display("[TB] FAIL %s: got %0d requests expected more than %0d", name, acc_addr.size(), idx);
    end else if (acc_addr[idx] !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, acc_addr[idx], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; lat = 2; stall = 1'b0; flush = 1'b0; req_ready = 1'b1; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_valid", {31'h0, req_valid}, 32'h0);
    chk("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_req_valid", {31'h0, req_valid}, 32'h1);
    chk("post_reset_req_addr", req_addr, 32'h0);
  endtask

  task automatic test_sequential();
    bit seen = 0;
    doReset(2, 1'b0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    chk("first_rsp_seen", {31'h0, seen}, 32'h1);
`ifdef IPQ_BYPASS_EN
    chk("bypass_valid_at_rsp", {31'h0, instr_valid}, 32'h1);
    chk("bypass_pc_at_rsp", instr_pc, 32'h0);
`else
    chk("no_valid_at_rsp", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("valid_at_rsp_plus1", {31'h0, instr_valid}, 32'h1);
    chk("pc_at_rsp_plus1", instr_pc, 32'h0);
    chk("instr_at_rsp_plus1", instr, memWord(32'h0));
`endif
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) chkAcc("seq_req_addr", i, 32'(i * 4));
    for (int i = 0; i < 4; i++) chkPc("seq_consume", i, 32'(i * 4));
  endtask

  task automatic test_stall_fill();
    logic [31:0] snapPc, snapInstr;
    int unstable = 0;
    doReset(2, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    snapPc = instr_pc;
    snapInstr = instr;
    chk("stall_head_pc", snapPc, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (instr_pc !== snapPc || instr !== snapInstr || instr_valid !== 1'b1) unstable++;
    end
    chk("stall_output_stable", 32'(unstable), 32'h0);
    chk("stall_req_count", 32'(acc_addr.size()), 32'd4);
    chk("stall_req_valid_low", {31'h0, req_valid}, 32'h0);
    chk("stall_none_consumed", 32'(cons_pc.size()), 32'd0);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) chkPc("stall_release_order", i, 32'(i * 4));
  endtask

  task automatic test_flush_drain();
    doReset(3, 1'b0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("flush_no_req", {31'h0, req_valid}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drain_no_req_1", {31'h0, req_valid}, 32'h0);
    chk("drain_instr_invalid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("drain_no_req_2", {31'h0, req_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("drain_exit_req_valid", {31'h0, req_valid}, 32'h1);
    chk("drain_exit_req_addr", req_addr, 32'h100);
    repeat (12) @(negedge clk);
    chkAcc("drain_third_req", 2, 32'h100);
    chkPc("drain_first_consume", 0, 32'h100);
    chkPc("drain_second_consume", 1, 32'h104);
  endtask

  task automatic test_flush_collision();
    doReset(2, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("collide_rsp_present", {31'h0, rsp_valid}, 32'h1);
    flush = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("collide_no_req", {31'h0, req_valid}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("collide_drain_no_req", {31'h0, req_valid}, 32'h0);
    chk("collide_instr_invalid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("collide_exit_req_valid", {31'h0, req_valid}, 32'h1);
    chk("collide_exit_req_addr", req_addr, 32'h200);
    repeat (12) @(negedge clk);
    chkAcc("collide_third_req", 2, 32'h200);
    chkPc("collide_first_consume", 0, 32'h200);
  endtask

  task automatic test_wrap();
    logic [31:0] exp [4];
    exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0; exp[3] = 32'h4;
    doReset(2, 1'b0);
    flush = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    flush = 1'b0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 4; i++) chkAcc("wrap_req_addr", i, exp[i]);
    for (int i = 0; i < 4; i++) chkPc("wrap_consume", i, exp[i]);
  endtask

  task automatic test_back_to_back();
    int badOrder = 0;
    doReset(2, 1'b1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      stall = (i % 4 == 3);
      req_ready = (i % 5 != 4);
      @(negedge clk);
    end
    stall = 1'b0;
    req_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (cons_pc.size() < 20) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d consumed expected at least 20", cons_pc.size());
    end
    for (int i = 0; i < cons_pc.size(); i++) begin
      if (cons_pc[i] !== 32'(i * 4) || cons_data[i] !== memWord(32'(i * 4))) badOrder++;
    end
    chk("b2b_order", 32'(badOrder), 32'h0);
  endtask

  task automatic test_midreset();
    doReset(2, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    chk("mid_valid_before", {31'h0, instr_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_reset_req_valid", {31'h0, req_valid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_reset_req_addr", req_addr, 32'h0);
    chk("mid_reset_instr_valid_after", {31'h0, instr_valid}, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_fill();
    test_flush_drain();
    test_flush_collision();
    test_wrap();
    test_back_to_back();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
